// File: rtl/rv32i_dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (C) and DMA (D): fixed CPU priority, DMA starvation guard, bounded DMA lock bursts.
// Accept and write in the same cycle; load data is registered with 1-cycle latency. A requester stalls while valid & !ready.
module rv32i_dmem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU port
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0]      c_wdata,
    input  logic [2:0]            c_func3,
    output logic                  c_rvalid,
    output logic [WIDTH-1:0]      c_rdata,
    // DMA port
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    input  logic [2:0]            d_func3,
    input  logic                  d_lock,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,
    // memory port
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(LOCK_MAX + 1);
    localparam bit LOCK_EN = (LOCK_MAX > 1);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_YIELD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [BEAT_W-1:0]   w_beat_inc;
    logic                w_wait_sat;
    logic                w_gnt_c;
    logic                w_gnt_d;
    logic                r_c_rvalid;
    logic                r_d_rvalid;
    logic [WIDTH-1:0]    r_c_rdata;
    logic [WIDTH-1:0]    r_d_rdata;

    assign w_wait_sat = (r_wait_cnt >= WAIT_W'(MAX_WAIT));
    assign w_beat_inc = r_beat_cnt + 1'b1;

    always_comb begin
        w_gnt_c     = 1'b0;
        w_gnt_d     = 1'b0;
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            ST_FREE: begin
                if (d_valid && w_wait_sat) begin
                    w_gnt_d = 1'b1;
                end else if (c_valid) begin
                    w_gnt_c = 1'b1;
                end else if (d_valid) begin
                    w_gnt_d = 1'b1;
                end
                if (w_gnt_d && d_lock && LOCK_EN) begin
                    w_state_nxt = ST_LOCKED;
                    w_beat_nxt  = BEAT_W'(1);
                end
            end
            ST_LOCKED: begin
                w_gnt_d = d_valid;
                if (w_gnt_d) begin
                    w_beat_nxt = w_beat_inc;
                end
                // Releasing the lock takes precedence over reaching the burst limit.
                if (!d_lock) begin
                    w_state_nxt = ST_FREE;
                    w_beat_nxt  = '0;
                end else if (w_gnt_d && (w_beat_inc == BEAT_W'(LOCK_MAX))) begin
                    w_state_nxt = ST_YIELD;
                end
            end
            ST_YIELD: begin
                w_gnt_c     = c_valid;
                w_state_nxt = ST_FREE;
                w_beat_nxt  = '0;
            end
            default: begin
                w_state_nxt = ST_FREE;
                w_beat_nxt  = '0;
            end
        endcase
        if (rst) begin
            w_gnt_c = 1'b0;
            w_gnt_d = 1'b0;
        end
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (r_state != ST_YIELD) begin
            if (!d_valid || w_gnt_d) begin
                w_wait_nxt = '0;
            end else if (!w_wait_sat) begin
                w_wait_nxt = r_wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        if (w_gnt_c) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_func3 = c_func3;
        end else if (w_gnt_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_func3 = d_func3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FREE;
            r_wait_cnt <= '0;
            r_beat_cnt <= '0;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_c_rvalid <= w_gnt_c && !c_we;
            r_d_rvalid <= w_gnt_d && !d_we;
            if (w_gnt_c && !c_we) begin
                r_c_rdata <= mem_rdata;
            end
            if (w_gnt_d && !d_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign c_ready  = w_gnt_c;
    assign d_ready  = w_gnt_d;
    assign c_rvalid = r_c_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
